// File: rtl/spi_frame_decoder_if.sv
// FIFO read side and byte stream bundle for spi_frame_decoder.
// master = decoder side, slave = FIFO/host side.
interface spi_frame_decoder_if;
  logic [63:0] in_fifo_data;
  logic        in_fifo_empty;
  logic        in_fifo_rd_en;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_first;
  logic        m_last;

  modport master (
    input  in_fifo_data,
    input  in_fifo_empty,
    input  m_ready,
    output in_fifo_rd_en,
    output m_data,
    output m_valid,
    output m_first,
    output m_last
  );

  modport slave (
    output in_fifo_data,
    output in_fifo_empty,
    output m_ready,
    input  in_fifo_rd_en,
    input  m_data,
    input  m_valid,
    input  m_first,
    input  m_last
  );
endinterface

// File: rtl/spi_frame_decoder.sv
// Un-rotates SPI sample words and re-frames chip bytes into hit frames.
// Optional SPI_FRAME_TIMESTAMP_EN appends a header-time stamp per frame.
module spi_frame_decoder #(
  parameter logic [7:0] IDLE_BYTE = 8'hBC,
  parameter int         MAX_LEN   = 8,
  parameter int         TS_WIDTH  = 32
) (
  input  logic                clock,
  input  logic                resetn,
  spi_frame_decoder_if.master bus,
  input  logic                clear_counts,
  output logic [15:0]         frame_count,
  output logic [7:0]          error_count
);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
`ifdef SPI_FRAME_TIMESTAMP_EN
  localparam logic [1:0] TS      = 2'd2;
  localparam int         NB      = TS_WIDTH / 8;
`endif
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);

  logic [1:0]  state;
  logic [63:0] word;
  logic        have_word;
  logic        rd_q;
  logic [2:0]  idx;
  logic [7:0]  remaining;

  logic [7:0] raw;
  logic [7:0] cur;
  logic       in_hunt;
  logic       in_pay;
  logic       avail;
  logic       is_idle;
  logic       hdr_ok;
  logic       drop;
  logic       bad_hdr;
  logic       out_free;
  logic       consume;
  logic       emit_in;
  logic       ts_emit;
  logic       emit;
  logic       frame_done;
  logic [7:0] nxt_data;
  logic       nxt_first;
  logic       nxt_last;

  // rd_q means in_fifo_data holds a fresh word this cycle: byte 0 bypasses
  assign raw = have_word ? word[{~idx, 3'b111} -: 8]
                         : bus.in_fifo_data[63:56];
  assign cur = {raw[5:0], raw[7:6]};

  assign in_hunt  = state == HUNT;
  assign in_pay   = state == PAYLOAD;
  assign avail    = have_word || rd_q;
  assign is_idle  = cur == IDLE_BYTE;
  assign hdr_ok   = (cur != 8'd0) && (cur <= MAX_B);
  assign drop     = in_hunt && (is_idle || !hdr_ok);
  assign bad_hdr  = in_hunt && !is_idle && !hdr_ok;
  assign out_free = !bus.m_valid || bus.m_ready;
  assign consume  = avail && (in_hunt || in_pay) && (drop || out_free);
  assign emit_in  = consume && !drop;
  assign emit     = emit_in || ts_emit;

  assign bus.in_fifo_rd_en = resetn && !rd_q && !bus.in_fifo_empty &&
                             (!have_word || (idx == 3'd7 && consume));

`ifdef SPI_FRAME_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_sr;
  logic [7:0]          ts_idx;
  logic                ts_last;

  assign ts_emit = (state == TS) && out_free;
  assign ts_last = ts_idx == 8'd0;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ts_cnt <= '0;
      ts_sr  <= '0;
      ts_idx <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (emit_in && in_hunt)
        ts_sr <= ts_cnt;
      else if (ts_emit)
        ts_sr <= ts_sr << 8;
      if (emit_in && in_pay && remaining == 8'd1)
        ts_idx <= 8'(NB - 1);
      else if (ts_emit)
        ts_idx <= ts_idx - 8'd1;
    end
  end
`else
  logic unused_ts;
  assign ts_emit   = 1'b0;
  assign unused_ts = (TS_WIDTH % 8) != 0;
`endif

  always_comb begin
    nxt_data  = cur;
    nxt_first = in_hunt;
    nxt_last  = in_pay && (remaining == 8'd1);
`ifdef SPI_FRAME_TIMESTAMP_EN
    nxt_last = ts_emit && ts_last;
    if (ts_emit)
      nxt_data = ts_sr[TS_WIDTH-1 -: 8];
`endif
  end

  assign frame_done = emit && nxt_last;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= HUNT;
      word        <= '0;
      have_word   <= 1'b0;
      rd_q        <= 1'b0;
      idx         <= '0;
      remaining   <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_first <= 1'b0;
      bus.m_last  <= 1'b0;
      frame_count <= '0;
      error_count <= '0;
    end else begin
      rd_q <= bus.in_fifo_rd_en;
      if (rd_q) begin
        word      <= bus.in_fifo_data;
        have_word <= 1'b1;
        idx       <= consume ? 3'd1 : 3'd0;
      end else if (consume) begin
        idx <= idx + 3'd1;
        if (idx == 3'd7)
          have_word <= 1'b0;
      end

      if (emit) begin
        bus.m_valid <= 1'b1;
        bus.m_data  <= nxt_data;
        bus.m_first <= nxt_first;
        bus.m_last  <= nxt_last;
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end

      case (state)
        HUNT: begin
          if (emit_in) begin
            state     <= PAYLOAD;
            remaining <= cur;
          end
        end
        PAYLOAD: begin
          if (emit_in) begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1)
`ifdef SPI_FRAME_TIMESTAMP_EN
              state <= TS;
`else
              state <= HUNT;
`endif
          end
        end
`ifdef SPI_FRAME_TIMESTAMP_EN
        TS: begin
          if (ts_emit && ts_last)
            state <= HUNT;
        end
`endif
        default: state <= HUNT;
      endcase

      if (clear_counts) begin
        frame_count <= '0;
        error_count <= '0;
      end else begin
        if (frame_done)
          frame_count <= frame_count + 16'd1;
        if (consume && bad_hdr && error_count != 8'hFF)
          error_count <= error_count + 8'd1;
      end
    end
  end

endmodule
